// File: rtl/cfa_pkg.sv
// Shared constants for the CFA cross-window generator: default pixel width,
// default image geometry and the window half-size.
package cfa_pkg;

    localparam int unsigned PixelBwDefault   = 12;
    localparam int unsigned ImgWidthDefault  = 640;
    localparam int unsigned ImgHeightDefault = 480;

    localparam int unsigned WinHalf = 2;
    localparam int unsigned WinTaps = 2 * WinHalf + 1;

endpackage

// File: rtl/cfa_line_buffer.sv
// Single-port line store: combinational read and synchronous write share one
// address, so a read in the write cycle returns the previous line's sample.
module cfa_line_buffer #(
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 640,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] addr,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cfa_cross_window_gen.sv
// Raster Bayer stream to 9-tap cross neighbourhood (centre row/column +-2),
// with the centre's Bayer phase and an end-of-frame pulse.
module cfa_cross_window_gen
    import cfa_pkg::*;
#(
    parameter int unsigned pixelBitWidth = PixelBwDefault,
    parameter int unsigned IMG_WIDTH     = ImgWidthDefault,
    parameter int unsigned IMG_HEIGHT    = ImgHeightDefault,
    parameter int unsigned COL_W         = 10,
    parameter int unsigned ROW_W         = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [pixelBitWidth-1:0] in_pixel,
    input  logic                     in_valid,
    input  logic                     in_sof,
    output logic [pixelBitWidth-1:0] p_m2_p0,
    output logic [pixelBitWidth-1:0] p_m1_p0,
    output logic [pixelBitWidth-1:0] p_p0_m2,
    output logic [pixelBitWidth-1:0] p_p0_m1,
    output logic [pixelBitWidth-1:0] p_p0_p0,
    output logic [pixelBitWidth-1:0] p_p0_p1,
    output logic [pixelBitWidth-1:0] p_p0_p2,
    output logic [pixelBitWidth-1:0] p_p1_p0,
    output logic [pixelBitWidth-1:0] p_p2_p0,
    output logic                     out_valid,
    output logic                     row_par,
    output logic                     col_par,
    output logic                     frame_done
);

    localparam int unsigned NumLines = 2 * WinHalf;
    localparam int unsigned VDelay   = WinHalf + 1;
    localparam logic [COL_W-1:0] LastCol = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LastRow = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] MinCol  = COL_W'(NumLines);
    localparam logic [ROW_W-1:0] MinRow  = ROW_W'(NumLines);

    typedef logic [pixelBitWidth-1:0] pix_t;

    logic [COL_W-1:0] col_cnt, col_cur;
    logic [ROW_W-1:0] row_cnt, row_cur;
    logic             done_q;
    logic             accept;
    logic             last_col, last_row;

    pix_t lb_rd [NumLines];
    pix_t lb_wr [NumLines];
    pix_t hsh [WinTaps];
    pix_t dly_m2 [VDelay];
    pix_t dly_m1 [VDelay];
    pix_t dly_p1 [VDelay];
    pix_t dly_p2 [VDelay];

    // Once the last pixel of a frame is taken, only a new sof is accepted.
    assign accept   = in_valid & (in_sof | ~done_q);
    assign col_cur  = in_sof ? '0 : col_cnt;
    assign row_cur  = in_sof ? '0 : row_cnt;
    assign last_col = (col_cur == LastCol);
    assign last_row = (row_cur == LastRow);

    // LB1 takes the new pixel; each deeper buffer takes its neighbour's old sample.
    always_comb begin
        lb_wr[0] = in_pixel;
        for (int k = 1; k < NumLines; k++) begin
            lb_wr[k] = lb_rd[k-1];
        end
    end

    for (genvar k = 0; k < NumLines; k++) begin : g_lb
        cfa_line_buffer #(
            .Width (pixelBitWidth),
            .Depth (IMG_WIDTH),
            .AddrW (COL_W)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col_cur),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            done_q     <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            row_par    <= 1'b0;
            col_par    <= 1'b0;
            for (int i = 0; i < WinTaps; i++) begin
                hsh[i] <= '0;
            end
            for (int i = 0; i < VDelay; i++) begin
                dly_m2[i] <= '0;
                dly_m1[i] <= '0;
                dly_p1[i] <= '0;
                dly_p2[i] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? row_cur : row_cur + ROW_W'(1);
                end else begin
                    col_cnt <= col_cur + COL_W'(1);
                    row_cnt <= row_cur;
                end
                done_q     <= last_row & last_col;
                out_valid  <= (row_cur >= MinRow) && (col_cur >= MinCol);
                frame_done <= last_row & last_col;
                // Centre sits two rows and two columns back, so its parity is the input's.
                row_par    <= row_cur[0];
                col_par    <= col_cur[0];

                hsh[0] <= lb_rd[1];
                for (int i = 1; i < WinTaps; i++) begin
                    hsh[i] <= hsh[i-1];
                end
                dly_m2[0] <= lb_rd[3];
                dly_m1[0] <= lb_rd[2];
                dly_p1[0] <= lb_rd[0];
                dly_p2[0] <= in_pixel;
                for (int i = 1; i < VDelay; i++) begin
                    dly_m2[i] <= dly_m2[i-1];
                    dly_m1[i] <= dly_m1[i-1];
                    dly_p1[i] <= dly_p1[i-1];
                    dly_p2[i] <= dly_p2[i-1];
                end
            end
        end
    end

    assign p_m2_p0 = dly_m2[VDelay-1];
    assign p_m1_p0 = dly_m1[VDelay-1];
    assign p_p1_p0 = dly_p1[VDelay-1];
    assign p_p2_p0 = dly_p2[VDelay-1];
    assign p_p0_p2 = hsh[0];
    assign p_p0_p1 = hsh[1];
    assign p_p0_p0 = hsh[2];
    assign p_p0_m1 = hsh[3];
    assign p_p0_m2 = hsh[4];

endmodule
